// File: rtl/msi_pkg.sv
// Shared types and encodings for the MSI request responder slice.
package msi_pkg;

  localparam int unsigned IDX_W       = 2;
  localparam int unsigned TAG_W       = 2;
  localparam int unsigned DATA_W      = 4;
  localparam int unsigned MEM_ENTRIES = 9;
  localparam logic [3:0]  ADDR_MIN    = 4'd1;
  localparam logic [3:0]  ADDR_MAX    = 4'd8;

  typedef enum logic [1:0] {L1_I = 2'b00, L1_S = 2'b01, L1_M = 2'b10} l1_state_e;
  typedef enum logic [1:0] {DIR_U = 2'b00, DIR_S = 2'b01, DIR_M = 2'b10} dir_state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01} op_e;
  typedef enum logic [1:0] {PROC_00 = 2'b00, PROC_01 = 2'b01} proc_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WB, ST_INV, ST_FILL, ST_RESP, ST_ERR
  } fsm_state_e;

  typedef struct packed {
    l1_state_e          state;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
  } l1_line_t;

  function automatic logic req_malformed(input logic [3:0] addr, input logic [1:0] op,
                                         input logic [1:0] proc);
    return (addr < ADDR_MIN) || (addr > ADDR_MAX) ||
           ((op != OP_READ) && (op != OP_WRITE)) ||
           ((proc != PROC_00) && (proc != PROC_01));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Direct-mapped private L1 storage: LINES entries of {state, tag, data},
// one asynchronous read port and one synchronous write port.
module l1_cache_array
  import msi_pkg::*;
#(
  parameter int unsigned LINES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output l1_line_t         o_rd_line,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  l1_line_t         i_wr_line
);

  l1_line_t r_lines [LINES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < LINES; i++) r_lines[i] <= '0;
    end else if (i_we) begin
      r_lines[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_line = r_lines[i_rd_idx];

endmodule

// File: rtl/msi_request_responder.sv
// MSI directory request responder: two L1s, directory, 9-entry memory and
// the servicing FSM. Optional counters enabled by defining MSI_STATS_EN.
module msi_request_responder
  import msi_pkg::*;
#(
  parameter int unsigned LINES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [3:0] ReqAddress,
  input  logic [1:0] ReqWriteOrRead,
  input  logic [1:0] ReqProcessor,
  input  logic [3:0] ReqData,
  output logic       RespValid,
  output logic [3:0] RespData,
  output logic       RespHit,
  output logic [1:0] RespState,
  output logic       RespError
`ifdef MSI_STATS_EN
  ,
  output logic [7:0] HitCount,
  output logic [7:0] MissCount,
  output logic [7:0] InvCount
`endif
);

  fsm_state_e r_state, w_next;
  logic [3:0] r_addr;
  logic [3:0] r_data;
  logic       r_wr;
  logic       r_p;
  logic       r_hit;

  logic [3:0] r_mem        [MEM_ENTRIES];
  dir_state_e r_dir_state  [MEM_ENTRIES];
  logic [1:0] r_dir_sharers[MEM_ENTRIES];

  l1_line_t w_line0, w_line1, w_req, w_oth;
  l1_line_t w_wl_req, w_wl_oth, w_wl0, w_wl1;
  logic     w_we_req, w_we_oth, w_we0, w_we1;
  logic     w_op;
  logic [TAG_W-1:0] w_tag;
  logic [3:0] w_vaddr;
  logic w_hit, w_victim_m, w_victim_s, w_need_inv;

  // Requester/other views are steered by the latched processor bit.
  assign w_op    = ~r_p;
  assign w_req   = r_p ? w_line1 : w_line0;
  assign w_oth   = r_p ? w_line0 : w_line1;
  assign w_we0   = r_p ? w_we_oth : w_we_req;
  assign w_we1   = r_p ? w_we_req : w_we_oth;
  assign w_wl0   = r_p ? w_wl_oth : w_wl_req;
  assign w_wl1   = r_p ? w_wl_req : w_wl_oth;
  assign w_tag   = r_addr[3:2];
  assign w_vaddr = {w_req.tag, r_addr[1:0]};

  assign w_hit      = (w_req.state != L1_I) && (w_req.tag == w_tag) &&
                      (!r_wr || (w_req.state == L1_M));
  assign w_victim_m = (w_req.state == L1_M) && (w_req.tag != w_tag);
  assign w_victim_s = (w_req.state == L1_S) && (w_req.tag != w_tag);
  assign w_need_inv = r_dir_sharers[r_addr][w_op] &&
                      (r_wr || (r_dir_state[r_addr] == DIR_M));

  l1_cache_array #(.LINES(LINES)) u_l1_p0 (
    .i_clk(Clock), .i_rst(Reset), .i_rd_idx(r_addr[1:0]), .o_rd_line(w_line0),
    .i_we(w_we0), .i_wr_idx(r_addr[1:0]), .i_wr_line(w_wl0)
  );

  l1_cache_array #(.LINES(LINES)) u_l1_p1 (
    .i_clk(Clock), .i_rst(Reset), .i_rd_idx(r_addr[1:0]), .o_rd_line(w_line1),
    .i_we(w_we1), .i_wr_idx(r_addr[1:0]), .i_wr_line(w_wl1)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_we_req = 1'b0;
    w_we_oth = 1'b0;
    w_wl_req = '0;
    w_wl_oth = '0;
    unique case (r_state)
      ST_IDLE:
        if (ReqValid)
          w_next = req_malformed(ReqAddress, ReqWriteOrRead, ReqProcessor) ? ST_ERR : ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit) begin
          w_next   = ST_RESP;
          w_we_req = r_wr;
          w_wl_req = '{state: L1_M, tag: w_tag, data: r_data};
        end else if (w_victim_m) w_next = ST_WB;
        else if (w_need_inv)     w_next = ST_INV;
        else                     w_next = ST_FILL;
      end
      ST_WB: begin
        w_next   = w_need_inv ? ST_INV : ST_FILL;
        w_we_req = 1'b1;
        w_wl_req = '{state: L1_I, tag: w_req.tag, data: w_req.data};
      end
      ST_INV: begin
        w_next   = ST_FILL;
        w_we_oth = 1'b1;
        w_wl_oth = '{state: (r_wr ? L1_I : L1_S), tag: w_oth.tag, data: w_oth.data};
      end
      ST_FILL: begin
        w_next   = ST_RESP;
        w_we_req = 1'b1;
        w_wl_req = '{state: (r_wr ? L1_M : L1_S), tag: w_tag,
                     data: (r_wr ? r_data : r_mem[r_addr])};
      end
      ST_RESP, ST_ERR: w_next = ST_IDLE;
      default:         w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
      r_p    <= 1'b0;
      r_hit  <= 1'b0;
    end else if (r_state == ST_IDLE && ReqValid) begin
      r_addr <= ReqAddress;
      r_data <= ReqData;
      r_wr   <= ReqWriteOrRead[0];
      r_p    <= ReqProcessor[0];
      r_hit  <= 1'b0;
    end else if (r_state == ST_LOOKUP) begin
      r_hit  <= w_hit;
    end
  end

  // Directory and memory; the victim and requester entries may both change in FILL.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < MEM_ENTRIES; i++) begin
        r_mem[i]         <= 4'(i);
        r_dir_state[i]   <= DIR_U;
        r_dir_sharers[i] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_WB: begin
          r_mem[w_vaddr]              <= w_req.data;
          r_dir_sharers[w_vaddr][r_p] <= 1'b0;
          r_dir_state[w_vaddr]        <= DIR_U;
        end
        ST_INV: begin
          if (w_oth.state == L1_M) r_mem[r_addr] <= w_oth.data;
          if (r_wr) r_dir_sharers[r_addr][w_op] <= 1'b0;
          else      r_dir_state[r_addr]         <= DIR_S;
        end
        ST_FILL: begin
          if (w_victim_s) begin
            r_dir_sharers[w_vaddr][r_p] <= 1'b0;
            r_dir_state[w_vaddr] <= r_dir_sharers[w_vaddr][w_op] ? DIR_S : DIR_U;
          end
          if (r_wr) begin
            r_dir_state[r_addr]   <= DIR_M;
            r_dir_sharers[r_addr] <= r_p ? 2'b10 : 2'b01;
          end else begin
            r_dir_state[r_addr]        <= DIR_S;
            r_dir_sharers[r_addr][r_p] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ReqReady  = (r_state == ST_IDLE) && !Reset;
  assign RespValid = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign RespError = (r_state == ST_ERR);
  assign RespHit   = (r_state == ST_RESP) && r_hit;
  assign RespData  = (r_state == ST_RESP) ? w_req.data : '0;
  assign RespState = (r_state == ST_RESP) ? w_req.state : '0;

`ifdef MSI_STATS_EN
  logic [7:0] r_hit_cnt, r_miss_cnt, r_inv_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_inv_cnt  <= '0;
    end else begin
      if (r_state == ST_RESP &&  r_hit) r_hit_cnt  <= sat_inc8(r_hit_cnt);
      if (r_state == ST_RESP && !r_hit) r_miss_cnt <= sat_inc8(r_miss_cnt);
      if (r_state == ST_INV)            r_inv_cnt  <= sat_inc8(r_inv_cnt);
    end
  end

  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
  assign InvCount  = r_inv_cnt;
`endif

endmodule

// File: tb/tb_msi_request_responder.sv
// Directed bench for msi_request_responder: hits, misses, write-backs,
// invalidations, malformed requests and reset abort.
module tb_msi_request_responder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqValid = 1'b0;
  logic       ReqReady;
  logic [3:0] ReqAddress = '0;
  logic [1:0] ReqWriteOrRead = '0;
  logic [1:0] ReqProcessor = '0;
  logic [3:0] ReqData = '0;
  logic       RespValid;
  logic [3:0] RespData;
  logic       RespHit;
  logic [1:0] RespState;
  logic       RespError;
`ifdef MSI_STATS_EN
  logic [7:0] HitCount, MissCount, InvCount;
`endif

  int tests = 0;
  int fails = 0;

  msi_request_responder #(.LINES(4)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddress(ReqAddress), .ReqWriteOrRead(ReqWriteOrRead),
    .ReqProcessor(ReqProcessor), .ReqData(ReqData), .RespValid(RespValid),
    .RespData(RespData), .RespHit(RespHit), .RespState(RespState),
    .RespError(RespError)
`ifdef MSI_STATS_EN
    , .HitCount(HitCount), .MissCount(MissCount), .InvCount(InvCount)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and check response contents and latency from the accept edge.
  task automatic req(input string tag, input logic [3:0] addr, input logic [1:0] op,
                     input logic [1:0] proc, input logic [3:0] data,
                     input logic [3:0] e_data, input logic e_hit, input logic [1:0] e_state,
                     input logic e_err, input int e_lat);
    int n;
    int lat;
    @(negedge Clock);
    ReqValid = 1'b1; ReqAddress = addr; ReqWriteOrRead = op;
    ReqProcessor = proc; ReqData = data;
    n = 0;
    while (ReqReady !== 1'b1 && n < 20) begin @(negedge Clock); n++; end
    chk({tag, ".ready"}, 16'(ReqReady), 16'd1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (RespValid !== 1'b1 && lat < 10) begin @(posedge Clock); #1; lat++; end
    chk({tag, ".lat"},   16'(lat),       16'(e_lat));
    chk({tag, ".data"},  16'(RespData),  16'(e_data));
    chk({tag, ".hit"},   16'(RespHit),   16'(e_hit));
    chk({tag, ".state"}, 16'(RespState), 16'(e_state));
    chk({tag, ".err"},   16'(RespError), 16'(e_err));
    @(posedge Clock); #1;
    chk({tag, ".clear"}, {7'd0, RespValid, RespHit, RespError, RespState, RespData}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst.ready", 16'(ReqReady),  16'd0);
    chk("rst.valid", 16'(RespValid), 16'd0);
    chk("rst.resp",  {9'd0, RespHit, RespError, RespState, RespData}, 16'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("idle.ready", 16'(ReqReady), 16'd1);

    //   tag         addr   op     proc   data    e_data e_hit e_state e_err lat
    req("rd1",       4'd1, 2'b00, 2'b00, 4'd0,   4'd1,  1'b0, 2'b01, 1'b0, 3);
    req("rd6",       4'd6, 2'b00, 2'b00, 4'd0,   4'd6,  1'b0, 2'b01, 1'b0, 3);
    req("wr6_upg",   4'd6, 2'b01, 2'b00, 4'd7,   4'd7,  1'b0, 2'b10, 1'b0, 3);
    req("rd6_hit",   4'd6, 2'b00, 2'b00, 4'd0,   4'd7,  1'b1, 2'b10, 1'b0, 2);
    req("rd5_evict", 4'd5, 2'b00, 2'b00, 4'd0,   4'd5,  1'b0, 2'b01, 1'b0, 3);
    req("p1_rd5",    4'd5, 2'b00, 2'b01, 4'd0,   4'd5,  1'b0, 2'b01, 1'b0, 3);
    req("p1_wr5",    4'd5, 2'b01, 2'b01, 4'd8,   4'd8,  1'b0, 2'b10, 1'b0, 4);
    req("p0_wr5",    4'd5, 2'b01, 2'b00, 4'd9,   4'd9,  1'b0, 2'b10, 1'b0, 4);
    req("p1_rd5_wb", 4'd5, 2'b00, 2'b01, 4'd0,   4'd9,  1'b0, 2'b01, 1'b0, 4);
    req("p0_rd5_hit",4'd5, 2'b00, 2'b00, 4'd0,   4'd9,  1'b1, 2'b01, 1'b0, 2);
    req("p0_rd2_wb", 4'd2, 2'b00, 2'b00, 4'd0,   4'd2,  1'b0, 2'b01, 1'b0, 4);
    req("p1_rd6",    4'd6, 2'b00, 2'b01, 4'd0,   4'd7,  1'b0, 2'b01, 1'b0, 3);
    req("p1_wr6",    4'd6, 2'b01, 2'b01, 4'd3,   4'd3,  1'b0, 2'b10, 1'b0, 3);
    req("p1_wr2",    4'd2, 2'b01, 2'b01, 4'd4,   4'd4,  1'b0, 2'b10, 1'b0, 5);
    req("p0_rd6",    4'd6, 2'b00, 2'b00, 4'd0,   4'd3,  1'b0, 2'b01, 1'b0, 3);
    req("err_addr0", 4'd0, 2'b00, 2'b00, 4'd0,   4'd0,  1'b0, 2'b00, 1'b1, 1);
    req("err_addr9", 4'd9, 2'b00, 2'b00, 4'd0,   4'd0,  1'b0, 2'b00, 1'b1, 1);
    req("err_op",    4'd5, 2'b10, 2'b00, 4'd0,   4'd0,  1'b0, 2'b00, 1'b1, 1);
    req("err_proc",  4'd5, 2'b00, 2'b11, 4'd0,   4'd0,  1'b0, 2'b00, 1'b1, 1);
    req("post_err",  4'd5, 2'b00, 2'b00, 4'd0,   4'd9,  1'b1, 2'b01, 1'b0, 2);

    // P0 upgrade of 0101 while P1 shares it: accept, LOOKUP, then reset during INV.
    @(negedge Clock);
    ReqValid = 1'b1; ReqAddress = 4'd5; ReqWriteOrRead = 2'b01;
    ReqProcessor = 2'b00; ReqData = 4'd0;
    chk("abort.ready", 16'(ReqReady), 16'd1);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    chk("abort.lookup_valid", 16'(RespValid), 16'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (3) begin
      @(posedge Clock); #1;
      chk("abort.valid", 16'(RespValid), 16'd0);
      chk("abort.ready", 16'(ReqReady),  16'd0);
    end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) begin
      @(posedge Clock); #1;
      chk("abort.no_resp", 16'(RespValid), 16'd0);
    end

    req("rst_rd5",   4'd5, 2'b00, 2'b00, 4'd0,   4'd5,  1'b0, 2'b01, 1'b0, 3);
    req("rst_rd6",   4'd6, 2'b00, 2'b01, 4'd0,   4'd6,  1'b0, 2'b01, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msi_request_responder.md
# msi_request_responder

Consumer end of the MSI directory test request stream. It accepts one processor request at a time (address code, read/write, processor, data) and services it against two private L1 caches (P0,0 and P0,1), a directory and a 9-entry backing memory. It runs the MSI state transitions, write-backs and invalidations, then returns one response per request. It sits directly behind the stimulus generator in the Pratica5 test harness.

## Interface
- `LINES`, 4: lines per L1. Direct-mapped; index = `ReqAddress[1:0]`, tag = `ReqAddress[3:2]`.
- `Clock` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high.
- `ReqValid` input 1: request present.
- `ReqReady` output 1: block can accept a request (IDLE only).
- `ReqAddress` input 4: address code. 0001..1000 map to 100..138; 0000 is empty.
- `ReqWriteOrRead` input 2: 00 Read, 01 Write, 10/11 reserved.
- `ReqProcessor` input 2: 00 P0,0, 01 P0,1, 10/11 reserved.
- `ReqData` input 4: write data code (0000..1001).
- `RespValid` output 1: one-cycle response strobe.
- `RespData` output 4: read data, or the written data on writes.
- `RespHit` output 1: 1 = L1 hit with no coherence action.
- `RespState` output 2: requester's L1 line state after the request. 00 I, 01 S, 10 M.
- `RespError` output 1: request was malformed.

## Operation
- FSM states: IDLE, LOOKUP, WB, INV, FILL, RESP, ERR. Each non-IDLE state lasts exactly one cycle.
- **Accept:** a handshake is `ReqValid && ReqReady`; all inputs are latched then. IDLE→LOOKUP, or IDLE→ERR if the address is 0000 or >1000, the op is reserved, or the processor is reserved.
- **Hit:**
  - Read hit (S or M), or write hit in M: update L1 data on a write, go LOOKUP→RESP, `RespHit`=1, no state change.
  - Write hit in S: treated as an upgrade (a miss).
- **Miss:** LOOKUP→WB if the victim line is valid, M and has a different tag. Otherwise →INV if coherence action is needed. Otherwise →FILL.
- **WB:** victim data goes to memory, the victim's directory sharer bit is cleared, then →INV or FILL.
- **INV:**
  - Read miss with the other L1 in M: the owner's data is written to memory and the owner goes M→S.
  - Write miss or upgrade: the other copy is invalidated; if it was M its data goes to memory first. Then →FILL.
- **FILL:**
  - A valid S victim is dropped silently and its sharer bit is cleared.
  - Read: the requester line is loaded from memory in S. Directory: Shared, requester sharer bit set.
  - Write: the requester line gets `ReqData` in M; memory is not updated (write-back). Directory: Modified, owner = requester.
  - Then →RESP.
- **RESP / ERR:** `RespValid`=1 for one cycle, then →IDLE. ERR drives `RespError`=1, `RespData`=0, `RespState`=00 and changes no state.
- **Memory reset contents:** entry k = k (so address 100 reads 0001). All L1 lines reset to I; all directory entries reset to Uncached with no sharers.

## Timing
- Reset values: `ReqReady`=0 while `Reset` is high and 1 in IDLE afterwards. All `Resp*` outputs are 0.
- Response latency, counted from the accept edge to the cycle with `RespValid`=1:
  - hit: 2 cycles
  - error: 1 cycle
  - plain miss: 3 cycles
  - miss plus one of WB/INV: 4 cycles
  - WB plus INV: 5 cycles
- `Resp*` outputs are valid only while `RespValid`=1; they return to 0 afterwards.
- `ReqValid` outside IDLE is ignored. The stimulus must hold the request until `ReqReady` is seen.
- Reset mid-operation: the FSM aborts to IDLE. All cache, directory and memory state returns to reset values, and no response is issued.

## Configuration
- `MSI_STATS_EN` defined: adds outputs `HitCount`, `MissCount`, `InvCount`, each 8-bit.
  - They increment on `RespValid`: a hit, a non-error miss, and each INV cycle respectively.
  - They saturate at 255 and clear on `Reset`.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- `msi_pkg` holds:
  - L1 state encodings (I/S/M)
  - directory encodings (Uncached/Shared/Modified)
  - op codes
  - processor codes
  - the valid address-code range
  - FSM state enum
- Sub-module `l1_cache_array`: `LINES` entries of {state, tag, data}, one read port and one write port, instantiated once per processor. The directory, memory and FSM live in the top module.

## Test plan
- P0,0 read 0001 after reset -> miss, 3-cycle latency, `RespData`=0001, `RespState`=S, `RespHit`=0.
- P0,0 read 0110, then write 0110←0111 -> the write is an upgrade (`RespHit`=0, `RespState`=M); a repeat read hits with `RespData`=0111.
- P0,0 read 0101 (same index as 0001) -> evicts the S line silently, `RespData`=0101; then P0,1 read 0101 -> both in S.
- P0,1 write 0101←1000, then P0,0 write 0101←1001 -> each write goes through INV. P0,1 then reads 0101 -> P0,0 is written back and goes M→S, `RespData`=1001, latency 4.
- Request with address 0000, or op 10, or processor 11 -> `RespError`=1 one cycle after accept, no state change.
- Assert `Reset` during INV -> no `RespValid`; afterwards a read of 0101 returns 0101, proving memory and caches were reset.
